bcd_store: RTL and testbench
============================

// Module: bcd_store
// PURPOSE
// - Sequential FX33 (LD B, Vx) write-back stage, directly downstream of the combinational bcd
//   converter: instantiates bcd, latches Vx and I on start, writes hundreds/tens/ones to
//   memory at I, I+1, I+2, one byte per accepted memory request.
// - Sits between the CPU execute FSM (start/busy/done) and the shared RAM write port (req/gnt).
// PARAMETERS
// - ADDR_WIDTH  12  memory address width; address arithmetic wraps modulo 2**ADDR_WIDTH
// PORTS
// - clk        in   1           system clock, all state on rising edge
// - rst_n      in   1           asynchronous, active-low reset
// - start      in   1           begin conversion; sampled only in IDLE
// - value      in   8           Vx, captured on accepted start
// - addr       in   ADDR_WIDTH  I register, captured on accepted start
// - busy       out  1           operation in progress
// - done       out  1           one-cycle pulse after last byte accepted
// - mem_we     out  1           write request to RAM port
// - mem_gnt    in   1           RAM port grant; write occurs on a cycle with mem_we && mem_gnt
// - mem_addr   out  ADDR_WIDTH  write address
// - mem_wdata  out  8           write data: {6'b0,hundreds} / {4'b0,tens} / {4'b0,ones}
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0;
//   latched value/addr cleared. Applies immediately, including mid-operation; an in-flight
//   write is abandoned, no further writes issued after release.
// - Registers: val_q[7:0], base_q[ADDR_WIDTH-1:0], state. bcd instance driven from val_q.
// - States: IDLE, WR_H, WR_T, WR_O, DONE.
//   IDLE: start=1 -> capture value->val_q, addr->base_q, go WR_H. start=0 -> stay.
//   WR_H: mem_we=1, mem_addr=base_q,   mem_wdata={6'b0,a}; gnt=1 -> WR_T, else hold.
//   WR_T: mem_we=1, mem_addr=base_q+1, mem_wdata={4'b0,b}; gnt=1 -> WR_O, else hold.
//   WR_O: mem_we=1, mem_addr=base_q+2, mem_wdata={4'b0,c}; gnt=1 -> DONE, else hold.
//   DONE: done=1 for exactly this cycle, busy=0, mem_we=0; unconditionally -> IDLE.
// - Outputs are registered/state-decoded: busy=1 exactly in WR_H/WR_T/WR_O.
// - mem_we, mem_addr, mem_wdata stable while mem_gnt=0 (no retraction, no skipped digit).
// - mem_we=0 in IDLE and DONE; mem_addr/mem_wdata don't-care there but must not glitch mem_we.
// - Address add is ADDR_WIDTH-bit, carry discarded: base 0xFFE -> 0xFFE, 0xFFF, 0x000.
// - start while busy or in DONE: ignored; latched value/addr unchanged.
// - start held high continuously: new operation begins each time IDLE is reached.
// - Latency with mem_gnt tied 1: start sampled at edge N -> writes at edges N+1..N+3,
//   done high during cycle after edge N+3; next start accepted at edge N+5.
// - value/addr inputs may change freely after the capturing edge.
// - Digit invariant: hundreds<=2, tens<=9, ones<=9; 100*h+10*t+o == val_q.
// TESTING
// - value=255, addr=0x200, gnt=1 -> writes (0x200,2),(0x201,5),(0x202,5) on 3 consecutive
//   edges; done 1 cycle later; busy=1 for exactly 3 cycles.
// - value=0, addr=0xFFE, gnt=1 -> writes (0xFFE,0),(0xFFF,0),(0x000,0); wrap checked.
// - value=107, gnt low 3 cycles during tens -> mem_we/addr/data held at (I+1,0) until
//   grant; sequence 1,0,7 with no duplicate or skipped write.
// - value=42 started, then start with value=99 while busy -> writes 0,4,2 only; second
//   start ignored.
// - rst_n low 1 cycle after hundreds accepted -> all outputs 0 immediately, no tens/ones
//   write; after release, start value=8 addr=0x300 -> writes 0,0,8 normally.
// - Sweep value 0..255, random addr, random gnt stalls -> every write triple matches
//   value/100, (value/10)%10, value%10 at I..I+2 (mod 2**ADDR_WIDTH); one done per start.

Source files
------------

// File: rtl/bcd_store.sv
// bcd: combinational binary-to-BCD conversion of one byte (shift-and-add-3).
// Latency: combinational, zero cycles.
// Backpressure: none; the output follows the input.
module bcd (
    input  logic [7:0] bin,
    output logic [1:0] a,
    output logic [3:0] b,
    output logic [3:0] c
);

    logic [17:0] sh;

    always_comb begin
        sh = {10'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sh[11:8] >= 4'd5)
                sh[11:8] = sh[11:8] + 4'd3;
            if (sh[15:12] >= 4'd5)
                sh[15:12] = sh[15:12] + 4'd3;
            // Hundreds never exceeds 2 for an 8-bit input, so it never needs the add-3 step.
            sh = sh << 1;
        end
        a = sh[17:16];
        b = sh[15:12];
        c = sh[11:8];
    end

endmodule

// bcd_store: writes the three BCD digits of a latched byte to memory at I, I+1 and I+2.
// Latency: start at edge N gives writes at N+1..N+3 with no stalls, then a done pulse.
// Backpressure: each write is held stable until mem_gnt; start is ignored while busy or done.
module bcd_store #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            value,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_we,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR_H = 3'd1,
        WR_T = 3'd2,
        WR_O = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [7:0]              val_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [1:0]              hund;
    logic [3:0]              tens;
    logic [3:0]              ones;

    bcd u_bcd (
        .bin (val_q),
        .a   (hund),
        .b   (tens),
        .c   (ones)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            val_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                val_q  <= value;
                base_q <= addr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = WR_H;
            WR_H:    if (mem_gnt) state_d = WR_T;
            WR_T:    if (mem_gnt) state_d = WR_O;
            WR_O:    if (mem_gnt) state_d = DONE;
            DONE:                 state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Outputs decode only the state register and latched operands, so they hold across stalls.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            WR_H: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = base_q;
                mem_wdata = {6'b0, hund};
            end
            WR_T: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = base_q + ADDR_WIDTH'(1);
                mem_wdata = {4'b0, tens};
            end
            WR_O: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = base_q + ADDR_WIDTH'(2);
                mem_wdata = {4'b0, ones};
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bcd_store.sv
// Scoreboard bench for bcd_store: expected writes queued at start, checked on each granted write.
module tb_bcd_store;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  value;
    logic [11:0] addr;
    logic        busy;
    logic        done;
    logic        mem_we;
    logic        mem_gnt;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t  exp_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   done_cnt  = 0;
    int   exp_done  = 0;
    logic pv_we     = 1'b0;
    logic pv_gnt    = 1'b0;
    logic [11:0] pv_addr = '0;
    logic [7:0]  pv_data = '0;

    bcd_store #(.ADDR_WIDTH(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .value     (value),
        .addr      (addr),
        .busy      (busy),
        .done      (done),
        .mem_we    (mem_we),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push3(input logic [7:0] v, input logic [11:0] a);
        wr_t e;
        e.a = a;               e.d = v / 8'd100;          exp_q.push_back(e);
        e.a = a + 12'd1;       e.d = (v / 8'd10) % 8'd10; exp_q.push_back(e);
        e.a = a + 12'd2;       e.d = v % 8'd10;           exp_q.push_back(e);
    endtask

    task automatic wait_done(input bit rnd);
        int n = 0;
        while (!done && n < 200) begin
            if (rnd) mem_gnt = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        mem_gnt = 1'b1;
    endtask

    task automatic run_op(input logic [7:0] v, input logic [11:0] a, input bit rnd);
        @(posedge clk); #1;
        start = 1'b1; value = v; addr = a;
        push3(v, a);
        exp_done++;
        @(posedge clk); #1;
        start = 1'b0;
        value = 8'($urandom);
        addr  = 12'($urandom);
        wait_done(rnd);
    endtask

    // Granted-write scoreboard, stall-hold checks and done accounting.
    always @(negedge clk) begin
        if (!rst_n) begin
            pv_we  = 1'b0;
            pv_gnt = 1'b0;
        end else begin
            if (pv_we && !pv_gnt) begin
                chk("hold_we",   {31'd0, mem_we}, 32'd1);
                chk("hold_addr", {20'd0, mem_addr}, {20'd0, pv_addr});
                chk("hold_data", {24'd0, mem_wdata}, {24'd0, pv_data});
            end
            if (mem_we && mem_gnt) begin
                chk("write_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", {20'd0, mem_addr}, {20'd0, e.a});
                    chk("wr_data", {24'd0, mem_wdata}, {24'd0, e.d});
                end
            end
            if (mem_we) chk("we_implies_busy", {31'd0, busy}, 32'd1);
            if (done) begin
                done_cnt++;
                chk("done_no_we",   {31'd0, mem_we}, 32'd0);
                chk("done_no_busy", {31'd0, busy}, 32'd0);
            end
            pv_we   = mem_we;
            pv_gnt  = mem_gnt;
            pv_addr = mem_addr;
            pv_data = mem_wdata;
        end
    end

    initial begin
        int busy_cnt;
        int done_at;

        rst_n = 1'b0; start = 1'b0; value = '0; addr = '0; mem_gnt = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_we",    {31'd0, mem_we}, 32'd0);
        chk("rst_addr",  {20'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        #2 rst_n = 1'b1;

        // 255 at 0x200: latency, busy width and done position.
        @(posedge clk); #1;
        start = 1'b1; value = 8'd255; addr = 12'h200;
        push3(8'd255, 12'h200);
        exp_done++;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = 0;
        done_at  = -1;
        for (int k = 0; k < 6; k++) begin
            if (busy) busy_cnt++;
            if (done && done_at < 0) done_at = k;
            @(posedge clk); #1;
        end
        chk("lat_busy_cycles", busy_cnt, 3);
        chk("lat_done_cycle", done_at, 3);

        // Address wrap.
        run_op(8'd0, 12'hFFE, 1'b0);

        // Grant withheld for three cycles during the tens write.
        @(posedge clk); #1;
        start = 1'b1; value = 8'd107; addr = 12'h400;
        push3(8'd107, 12'h400);
        exp_done++;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_we",   {31'd0, mem_we}, 32'd1);
            chk("stall_addr", {20'd0, mem_addr}, 32'h401);
            chk("stall_data", {24'd0, mem_wdata}, 32'd0);
            @(posedge clk); #1;
        end
        mem_gnt = 1'b1;
        wait_done(1'b0);

        // Start while busy is ignored.
        @(posedge clk); #1;
        start = 1'b1; value = 8'd42; addr = 12'h050;
        push3(8'd42, 12'h050);
        exp_done++;
        @(posedge clk); #1;
        value = 8'd99; addr = 12'h777;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0);
        repeat (3) @(posedge clk);

        // Start held high: operations accepted at edges N, N+5, N+10.
        @(posedge clk); #1;
        start = 1'b1; value = 8'd63; addr = 12'h123;
        for (int k = 0; k < 3; k++) push3(8'd63, 12'h123);
        exp_done += 3;
        repeat (11) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("held_start_drained", exp_q.size(), 0);

        // Reset after the hundreds write: outputs clear at once, rest of the triple abandoned.
        @(posedge clk); #1;
        start = 1'b1; value = 8'd123; addr = 12'h100;
        push3(8'd123, 12'h100);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",  {31'd0, busy}, 32'd0);
        chk("arst_we",    {31'd0, mem_we}, 32'd0);
        chk("arst_done",  {31'd0, done}, 32'd0);
        chk("arst_addr",  {20'd0, mem_addr}, 32'd0);
        chk("arst_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("arst_pending", exp_q.size(), 2);
        exp_q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_we",   {31'd0, mem_we}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        run_op(8'd8, 12'h300, 1'b0);

        // Full value sweep with random addresses and grant stalls.
        for (int v = 0; v < 256; v++)
            run_op(8'(v), 12'($urandom), 1'b1);

        repeat (4) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);
        chk("done_count", done_cnt, exp_done);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
